// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, rx state encoding and parity helper
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_e;
  // Payload is zero-extended to 9 bits; the padding does not change the XOR
  function automatic logic parity_bit(input int mode, input logic [8:0] d);
    return (mode == PARITY_ODD) ? ~^d : ^d;
  endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for asynchronous inputs
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic s1_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q_o, s1_q} <= {2{RST_VAL}};
    else {q_o, s1_q} <= {s1_q, d_i};
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with mid-bit sampling,
// false-start filter and a one-entry valid/ready output buffer
module uart_rx_param import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_in,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  logic                 rx_s;
  logic                 tick;
  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bad_q;
  logic                 stop_idx_q;
  uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d_i(data_in), .q_o(rx_s));
  assign tick = (cnt_q == LAST);
  assign busy = (state_q != IDLE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      stop_idx_q <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      if (valid && ready) valid <= 1'b0;
      case (state_q)
        IDLE: if (!rx_s) begin
          state_q <= START;
          cnt_q   <= '0;
        end
        START: if (cnt_q == HALF_M1) begin
          state_q <= rx_s ? IDLE : DATA;
          cnt_q   <= '0;
          idx_q   <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        // LSB arrives first, so shift right and it ends at bit 0
        DATA: if (tick) begin
          cnt_q   <= '0;
          shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_q    <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            par_bad_q  <= 1'b0;
            stop_idx_q <= 1'b0;
          end
        end else cnt_q <= cnt_q + 1'b1;
        PARITY: if (tick) begin
          cnt_q     <= '0;
          par_bad_q <= rx_s != parity_bit(PARITY_MODE, 9'(shift_q));
          state_q   <= STOP;
        end else cnt_q <= cnt_q + 1'b1;
        STOP: if (tick) begin
          cnt_q <= '0;
          if (!rx_s) begin
            frame_err <= 1'b1;
            state_q   <= BREAK;
          end else if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            state_q <= IDLE;
            if (par_bad_q) parity_err <= 1'b1;
            else if (!valid || ready) begin
              data_out <= shift_q;
              valid    <= 1'b1;
            end else overrun <= 1'b1;
          end else stop_idx_q <= 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
        BREAK: if (rx_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed scoreboard bench over three receiver configurations
module tb_uart_rx_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] din = 3'b111;
  logic [2:0] rdy = 3'b111;
  logic [2:0] v, pe, fe, ov, bz;
  logic [7:0] dout0, dout1;
  logic [6:0] dout2;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pe_n[3], fe_n[3], ov_n[3], vc[3], rise[3];
  logic [2:0] vprev = 3'b000;
  logic [10:0] exp_q[$];

  uart_rx_param u0 (.clk(clk), .rst_n(rst_n), .data_in(din[0]), .ready(rdy[0]), .data_out(dout0),
    .valid(v[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .busy(bz[0]));
  uart_rx_param #(.PARITY_MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .data_in(din[1]), .ready(rdy[1]),
    .data_out(dout1), .valid(v[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .busy(bz[1]));
  uart_rx_param #(.CLKS_PER_BIT(5), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u2 (.clk(clk),
    .rst_n(rst_n), .data_in(din[2]), .ready(rdy[2]), .data_out(dout2), .valid(v[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .busy(bz[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [8:0] g;
      logic [10:0] e;
      g = (i == 0) ? 9'(dout0) : (i == 1) ? 9'(dout1) : 9'(dout2);
      pe_n[i] += int'(pe[i]);
      fe_n[i] += int'(fe[i]);
      ov_n[i] += int'(ov[i]);
      vc[i]   += int'(v[i]);
      if (v[i] && !vprev[i]) rise[i] = cyc;
      if (v[i] && rdy[i]) begin
        check("q_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("inst", i, 32'(e[10:9]));
          check("data", 32'(g), 32'(e[8:0]));
        end
      end
    end
    vprev = v;
  end

  task automatic drive(input int i, input logic b, input int n);
    din[i] = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [8:0] d, input int nb, input int par,
                      input int stops, input int cpb, input logic stopv);
    drive(i, 1'b0, cpb);
    for (int b = 0; b < nb; b++) drive(i, d[b], cpb);
    if (par >= 0) drive(i, par[0], cpb);
    for (int s = 0; s < stops; s++) drive(i, stopv, cpb);
  endtask

  initial begin
    int s;
    logic [7:0] d8;
    logic [6:0] d7;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(v), 0);
    check("rst_busy", 32'(bz), 0);
    check("rst_errs", 32'({pe, fe, ov}), 0);
    check("rst_dout0", 32'(dout0), 0);
    check("rst_dout2", 32'(dout2), 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    // default config: 0xA5 delivered, latency 9.5 bit-times + 3 clk
    exp_q.push_back({2'd0, 9'h0A5});
    s = cyc;
    send(0, 9'h0A5, 8, -1, 1, 16, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("a5_latency", rise[0] - s, 152 + 3);
    check("a5_valid_cycles", vc[0], 1);
    check("a5_drained", exp_q.size(), 0);
    check("a5_errs", pe_n[0] + fe_n[0] + ov_n[0], 0);
    // even parity: correct bit delivers, wrong bit flags parity_err
    d8 = 8'h03;
    exp_q.push_back({2'd1, 9'h003});
    send(1, 9'(d8), 8, int'(^d8), 1, 16, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("par_ok_drained", exp_q.size(), 0);
    check("par_ok_pe", pe_n[1], 0);
    send(1, 9'(d8), 8, int'(~^d8), 1, 16, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("par_bad_pe", pe_n[1], 1);
    check("par_bad_valid_cycles", vc[1], 1);
    check("par_bad_v", 32'(v[1]), 0);
    // short glitch is rejected by the mid-start check
    drive(0, 1'b0, 5);
    check("glitch_busy", 32'(bz[0]), 1);
    drive(0, 1'b1, 20);
    check("glitch_idle", 32'(bz[0]), 0);
    check("glitch_vc", vc[0], 1);
    check("glitch_errs", pe_n[0] + fe_n[0] + ov_n[0], 0);
    // stop bit low then held low: one frame_err, no retrigger
    send(0, 9'h000, 8, -1, 1, 16, 1'b0);
    drive(0, 1'b0, 40 * 16);
    check("brk_fe", fe_n[0], 1);
    check("brk_busy", 32'(bz[0]), 1);
    check("brk_vc", vc[0], 1);
    drive(0, 1'b1, 16);
    check("brk_released", 32'(bz[0]), 0);
    exp_q.push_back({2'd0, 9'h05A});
    send(0, 9'h05A, 8, -1, 1, 16, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("brk_5a_drained", exp_q.size(), 0);
    check("brk_fe_total", fe_n[0], 1);
    // consumer stalled: second frame overruns and first word is held
    rdy[0] = 1'b0;
    exp_q.push_back({2'd0, 9'h011});
    send(0, 9'h011, 8, -1, 1, 16, 1'b1);
    send(0, 9'h022, 8, -1, 1, 16, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("ovr_pulse", ov_n[0], 1);
    check("ovr_valid", 32'(v[0]), 1);
    check("ovr_dout", 32'(dout0), 32'h11);
    rdy[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ovr_valid_drop", 32'(v[0]), 0);
    check("ovr_drained", exp_q.size(), 0);
    // 7 bits, odd parity, 2 stops, 5 clk/bit
    rdy[2] = 1'b0;
    d7 = 7'h7F;
    send(2, 9'(d7), 7, int'(~^d7), 2, 5, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("c2_valid", 32'(v[2]), 1);
    check("c2_dout", 32'(dout2), 32'h7F);
    check("c2_errs", pe_n[2] + fe_n[2] + ov_n[2], 0);
    drive(2, 1'b0, 5);
    drive(2, 1'b1, 5);
    drive(2, 1'b0, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(v[2]), 0);
    check("midrst_dout", 32'(dout2), 0);
    check("midrst_busy", 32'(bz[2]), 0);
    din[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    d7 = 7'h2A;
    exp_q.push_back({2'd2, 9'h02A});
    send(2, 9'(d7), 7, int'(~^d7), 2, 5, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("c2_after_rst_drained", exp_q.size(), 0);
    check("c2_after_rst_errs", pe_n[2] + fe_n[2] + ov_n[2], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
